// File: rtl/param_bus_cpu_pkg.sv
// param_bus_cpu_pkg: shared opcodes and FSM state encoding for param_bus_cpu.
//   Exports OP_MV..OP_NOP (3-bit opcodes) and state_t (IDLE=0, T1=1, T2=2, T3=3).
package param_bus_cpu_pkg;
    localparam logic [2:0] OP_MV  = 3'd0;
    localparam logic [2:0] OP_MVI = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOP = 3'd7;
    typedef enum logic [1:0] {IDLE = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;
endpackage

// File: rtl/param_bus_alu.sv
// param_bus_alu: combinational ALU for param_bus_cpu.
//   op     in  3      opcode (ADD/SUB/AND/OR/XOR; others yield 0)
//   a, b   in  WIDTH  operands (result = a op b)
//   result out WIDTH  result modulo 2^WIDTH
//   carry  out 1      carry-out for ADD, borrow (a<b unsigned) for SUB, else 0
module param_bus_alu import param_bus_cpu_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry
);
    logic [WIDTH:0] sum, diff;
    assign sum  = {1'b0, a} + {1'b0, b};
    // Top bit of the widened difference is set exactly when a < b.
    assign diff = {1'b0, a} - {1'b0, b};
    always_comb begin
        result = op == OP_ADD ? sum[WIDTH-1:0] :
                 op == OP_SUB ? diff[WIDTH-1:0] :
                 op == OP_AND ? a & b :
                 op == OP_OR  ? a | b :
                 op == OP_XOR ? a ^ b : '0;
        carry  = op == OP_ADD ? sum[WIDTH] :
                 op == OP_SUB ? diff[WIDTH] : 1'b0;
    end
endmodule

// File: rtl/param_bus_cpu.sv
// param_bus_cpu: multicycle register-file CPU with a shared internal bus, A/G registers and an ALU.
//   clk, rst (async, active-high), start/instr {op,rx,ry}, data_in (MVI immediate)
//   done (pulse on destination write), busy (state != IDLE), regs_out (R[i] at [i*WIDTH +: WIDTH]), state
//   Optional macro CPU_FLAGS_EN adds flag_z/flag_c, updated in T2 of ALU ops.
module param_bus_cpu import param_bus_cpu_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int RB    = $clog2(NREGS),
    parameter int IW    = 3 + 2 * RB
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [IW-1:0]          instr,
    input  logic [WIDTH-1:0]       data_in,
    output logic                   done,
    output logic                   busy,
    output logic [NREGS*WIDTH-1:0] regs_out,
    output logic [1:0]             state
`ifdef CPU_FLAGS_EN
    ,
    output logic                   flag_z,
    output logic                   flag_c
`endif
);
    state_t cur, nxt;
    logic [IW-1:0] ir;
    logic [WIDTH-1:0] r [NREGS];
    logic [WIDTH-1:0] a, g, bus, alu_res;
    logic alu_c, is_alu, wr;
    logic [2:0] op;
    logic [RB-1:0] rx, ry;
    assign op = ir[IW-1 -: 3];
    assign rx = ir[2*RB-1 -: RB];
    assign ry = ir[RB-1:0];
    assign is_alu = op inside {[OP_ADD:OP_XOR]};
    assign state = cur;
    assign busy = cur != IDLE;
    param_bus_alu #(.WIDTH(WIDTH)) u_alu (.op(op), .a(a), .b(bus), .result(alu_res), .carry(alu_c));
    for (genvar i = 0; i < NREGS; i++) begin : g_out
        assign regs_out[i*WIDTH +: WIDTH] = r[i];
    end
    // Single bus driver per state: T1 feeds the destination (MV/MVI) or A (ALU ops), T2 feeds ry to the ALU, T3 returns G.
    always_comb begin
        bus  = cur == T1 ? (op == OP_MVI ? data_in : op == OP_MV ? r[ry] : r[rx]) :
               cur == T2 ? r[ry] :
               cur == T3 ? g : '0;
        wr   = (cur == T1 && (op == OP_MV || op == OP_MVI)) || cur == T3;
        done = (cur == T1 && !is_alu) || cur == T3;
        nxt  = cur == IDLE ? (start ? T1 : IDLE) :
               cur == T1   ? (is_alu ? T2 : IDLE) :
               cur == T2   ? T3 : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= IDLE;
            ir  <= '0;
            a   <= '0;
            g   <= '0;
            for (int k = 0; k < NREGS; k++) r[k] <= '0;
`ifdef CPU_FLAGS_EN
            flag_z <= 1'b0;
            flag_c <= 1'b0;
`endif
        end else begin
            cur <= nxt;
            if (cur == IDLE && start) ir <= instr;
            if (cur == T1 && is_alu) a <= bus;
            if (cur == T2) g <= alu_res;
            if (wr) r[rx] <= bus;
`ifdef CPU_FLAGS_EN
            if (cur == T2) begin
                flag_z <= alu_res == '0;
                flag_c <= alu_c;
            end
`endif
        end
    end
endmodule

// File: tb/tb_param_bus_cpu.sv
// tb_param_bus_cpu: directed self-checking bench for param_bus_cpu (WIDTH=16, NREGS=8).
module tb_param_bus_cpu;
    import param_bus_cpu_pkg::*;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [8:0] instr = '0;
    logic [15:0] data_in = '0;
    logic done, busy, flag_z, flag_c;
    logic [127:0] regs_out;
    logic [1:0] state;
    int errors = 0, checks = 0;
    param_bus_cpu dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .data_in(data_in),
        .done(done), .busy(busy), .regs_out(regs_out), .state(state)
`ifdef CPU_FLAGS_EN
        , .flag_z(flag_z), .flag_c(flag_c)
`endif
    );
`ifndef CPU_FLAGS_EN
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
`endif
    always #5 clk = ~clk;
    function automatic logic [15:0] rg(input int i);
        return regs_out[i*16 +: 16];
    endfunction
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // Issue one instruction from IDLE, measure start->done latency, then wait for the write.
    task automatic run(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                       input logic [15:0] d, input int lat);
        int n = 0;
        instr = {op, rx, ry};
        data_in = d;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                break;
            end
            @(posedge clk);
        end
        check($sformatf("latency op%0d", op), n, lat);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("idle op%0d", op), {busy, state}, 3'b000);
    endtask
    initial begin
        logic [127:0] snap;
        logic [1:0] fl;
        int cnt;
        repeat (2) @(negedge clk);
        check("reset regs", regs_out, '0);
        check("reset state", {done, busy, state}, 4'b0000);
        rst = 1'b0;
        // Reset in T2 of an ADD aborts with no write.
        run(OP_MVI, 3'd0, 3'd0, 16'h0001, 1);
        run(OP_MVI, 3'd1, 3'd0, 16'h0002, 1);
        instr = {OP_ADD, 3'd0, 3'd1};
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("in T2", state, 2'd2);
        rst = 1'b1;
        #1;
        check("abort state", {done, busy, state}, 4'b0000);
        check("abort regs", regs_out, '0);
        @(negedge clk);
        rst = 1'b0;
        // MVI / MV
        run(OP_MVI, 3'd3, 3'd0, 16'h00A5, 1);
        check("R3 mvi", rg(3), 16'h00A5);
        run(OP_MV, 3'd1, 3'd3, 16'h1234, 1);
        check("R1 mv", rg(1), 16'h00A5);
        // ADD with wrap
        run(OP_MVI, 3'd0, 3'd0, 16'hFFFF, 1);
        run(OP_MVI, 3'd1, 3'd0, 16'h0001, 1);
        run(OP_ADD, 3'd0, 3'd1, 16'h0000, 3);
        check("R0 add wrap", rg(0), 16'h0000);
`ifdef CPU_FLAGS_EN
        check("flags add wrap", {flag_z, flag_c}, 2'b11);
`endif
        run(OP_ADD, 3'd3, 3'd1, 16'h0000, 3);
        check("R3 add", rg(3), 16'h00A6);
`ifdef CPU_FLAGS_EN
        check("flags add", {flag_z, flag_c}, 2'b00);
`endif
        // SUB borrow, XOR self
        run(OP_MVI, 3'd2, 3'd0, 16'h0000, 1);
        run(OP_SUB, 3'd2, 3'd1, 16'h0000, 3);
        check("R2 sub", rg(2), 16'hFFFF);
`ifdef CPU_FLAGS_EN
        check("flags sub", {flag_z, flag_c}, 2'b01);
`endif
        run(OP_XOR, 3'd2, 3'd2, 16'h0000, 3);
        check("R2 xor", rg(2), 16'h0000);
`ifdef CPU_FLAGS_EN
        check("flags xor", {flag_z, flag_c}, 2'b10);
`endif
        // AND / OR
        run(OP_MVI, 3'd5, 3'd0, 16'h0FF0, 1);
        run(OP_MVI, 3'd6, 3'd0, 16'h3C3C, 1);
        run(OP_AND, 3'd5, 3'd6, 16'h0000, 3);
        check("R5 and", rg(5), 16'h0C30);
        run(OP_OR, 3'd6, 3'd5, 16'h0000, 3);
        check("R6 or", rg(6), 16'h3C3C);
        run(OP_SUB, 3'd6, 3'd5, 16'h0000, 3);
        check("R6 sub", rg(6), 16'h300C);
        // start held high through an ADD: one done, one execution
        run(OP_MVI, 3'd4, 3'd0, 16'h0005, 1);
        run(OP_MVI, 3'd5, 3'd0, 16'h0003, 1);
        instr = {OP_ADD, 3'd4, 3'd5};
        start = 1'b1;
        cnt = 0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (done) cnt++;
        end
        check("held done count", cnt, 1);
        check("held back idle", state, 2'd0);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("held stays idle", {busy, state}, 3'b000);
        check("R4 add once", rg(4), 16'h0008);
        // NOP leaves everything unchanged
        snap = regs_out;
        fl = {flag_z, flag_c};
        run(OP_NOP, 3'd4, 3'd5, 16'hDEAD, 1);
        check("nop regs", regs_out, snap);
        check("nop flags", {flag_z, flag_c}, fl);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
